// File: rtl/led_seq_pkg.sv
// led_seq_pkg
//   Shared types and constants for the LED phase sequencer.
//   - state_t : sequencer FSM states (one settle + one acquire per phase)
//   - phase_t : phase-select codes derived from the state
//   - DC_W / PGA_W / ADC_W : AFE field widths
//   - helpers : state classification and a saturating subtractor
package led_seq_pkg;

    localparam int DC_W  = 7;
    localparam int PGA_W = 4;
    localparam int ADC_W = 8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RED_SETTLE = 3'd1,
        S_RED_ACQ    = 3'd2,
        S_IR_SETTLE  = 3'd3,
        S_IR_ACQ     = 3'd4,
        S_AMB_SETTLE = 3'd5,
        S_AMB_ACQ    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_RED  = 2'd1,
        PH_IR   = 2'd2,
        PH_AMB  = 2'd3
    } phase_t;

    function automatic phase_t phase_of(input state_t s);
        phase_t p;
        case (s)
            S_RED_SETTLE, S_RED_ACQ: p = PH_RED;
            S_IR_SETTLE,  S_IR_ACQ:  p = PH_IR;
            S_AMB_SETTLE, S_AMB_ACQ: p = PH_AMB;
            default:                 p = PH_NONE;
        endcase
        return p;
    endfunction

    function automatic logic is_settle(input state_t s);
        return (s == S_RED_SETTLE) || (s == S_IR_SETTLE) || (s == S_AMB_SETTLE);
    endfunction

    function automatic logic is_acq(input state_t s);
        return (s == S_RED_ACQ) || (s == S_IR_ACQ) || (s == S_AMB_ACQ);
    endfunction

    // a - b clamped at zero (ambient can exceed the LED-lit reading).
    function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] a,
                                                 input logic [ADC_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/sample_accumulator.sv
// sample_accumulator
//   Sums 2^ACQ_LOG2 ADC samples and presents their truncated mean. One
//   instance is shared by all three phases; the sequencer clears it during
//   every settle window.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     clr  - clear the running sum this cycle
//     add  - add ADC into the running sum this cycle
//     ADC  - current ADC sample
//     avg  - (running sum + current ADC) >> ACQ_LOG2; valid on the last
//            acquisition cycle, so the final sample needs no extra cycle
module sample_accumulator
    import led_seq_pkg::*;
#(
    parameter int ACQ_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [ADC_W-1:0] ADC,
    output logic [ADC_W-1:0] avg
);

    // 2^ACQ_LOG2 samples of at most 255 always fit in ADC_W+ACQ_LOG2 bits.
    localparam int ACC_W = ADC_W + ACQ_LOG2;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;

    assign w_sum = r_acc + ACC_W'(ADC);
    assign avg   = w_sum[ACC_W-1:ACQ_LOG2];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc <= '0;
        end else if (add) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/led_phase_sequencer.sv
// led_phase_sequencer
//   Time-multiplexes the photodiode AFE over RED, IR and ambient phases.
//   Each phase: drive LEDs/DC_Comp/PGA_Gain, wait SETTLE_CYC cycles, then
//   average 2^ACQ_LOG2 ADC samples. One coherent RED/IR/AMB triple is
//   published per frame with a one-cycle sample_valid strobe.
//   Optional build macro: AMB_SUB_EN -- publish RED/IR as (pending - ambient)
//   saturated at 0; AMB_ADC_Value stays raw.
//   Ports:
//     CLK, rst            - clock, synchronous active-high reset
//     enable              - run frames while high (checked at frame end)
//     cfg_load, cfg_*     - shadow-register load of per-LED DC/PGA settings
//     ADC                 - ADC sample, valid every cycle
//     LED_RED, LED_IR     - LED enables
//     DC_Comp, PGA_Gain   - AFE settings for the current phase
//     *_ADC_Value         - published per-frame averages
//     sample_valid        - one-cycle pulse when the triple updates
//     frame_cnt           - completed frame count, wraps 255->0
//     busy                - high whenever the FSM is not idle
//     dbg_state           - current FSM state (debug visibility)
module led_phase_sequencer
    import led_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int ACQ_LOG2   = 2
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic [DC_W-1:0]  cfg_red_dc,
    input  logic [PGA_W-1:0] cfg_red_pga,
    input  logic [DC_W-1:0]  cfg_ir_dc,
    input  logic [PGA_W-1:0] cfg_ir_pga,
    input  logic [ADC_W-1:0] ADC,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [DC_W-1:0]  DC_Comp,
    output logic [PGA_W-1:0] PGA_Gain,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic [ADC_W-1:0] AMB_ADC_Value,
    output logic             sample_valid,
    output logic [7:0]       frame_cnt,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int         ACQ_N       = 1 << ACQ_LOG2;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] ACQ_LAST    = 8'(ACQ_N - 1);

    // ------------------------------------------------------------------
    // State and phase counter
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic [7:0] r_cnt;
    logic       w_phase_done;

    // Shadow (loaded any time) and active (frame-stable) settings
    logic [DC_W-1:0]  r_shd_red_dc,  r_act_red_dc,  w_act_red_dc_nxt;
    logic [PGA_W-1:0] r_shd_red_pga, r_act_red_pga, w_act_red_pga_nxt;
    logic [DC_W-1:0]  r_shd_ir_dc,   r_act_ir_dc,   w_act_ir_dc_nxt;
    logic [PGA_W-1:0] r_shd_ir_pga,  r_act_ir_pga,  w_act_ir_pga_nxt;
    logic             w_enter_red;

    // Registered-output next values
    logic             w_led_red_nxt;
    logic             w_led_ir_nxt;
    logic [DC_W-1:0]  w_dc_nxt;
    logic [PGA_W-1:0] w_pga_nxt;

    // Accumulator / results
    logic             w_acc_clr;
    logic             w_acc_add;
    logic [ADC_W-1:0] w_avg;
    logic [ADC_W-1:0] r_red_pend;
    logic [ADC_W-1:0] r_ir_pend;
    logic [ADC_W-1:0] w_red_pub;
    logic [ADC_W-1:0] w_ir_pub;
    logic             w_publish;

    assign dbg_state = r_state;

    // ------------------------------------------------------------------
    // FSM next state, plus next values of every registered output
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_done = 1'b0;
        if (is_settle(r_state)) begin
            w_phase_done = (r_cnt == SETTLE_LAST);
        end else if (is_acq(r_state)) begin
            w_phase_done = (r_cnt == ACQ_LAST);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (enable)       w_state_nxt = S_RED_SETTLE;
            S_RED_SETTLE: if (w_phase_done) w_state_nxt = S_RED_ACQ;
            S_RED_ACQ:    if (w_phase_done) w_state_nxt = S_IR_SETTLE;
            S_IR_SETTLE:  if (w_phase_done) w_state_nxt = S_IR_ACQ;
            S_IR_ACQ:     if (w_phase_done) w_state_nxt = S_AMB_SETTLE;
            S_AMB_SETTLE: if (w_phase_done) w_state_nxt = S_AMB_ACQ;
            // enable is only looked at here, so a frame always runs to completion
            S_AMB_ACQ:    if (w_phase_done) w_state_nxt = enable ? S_RED_SETTLE : S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    // Settings move shadow->active only when a frame begins. A cfg_load on
    // that same edge bypasses the shadow so the new values take effect now.
    always_comb begin
        w_enter_red       = (w_state_nxt == S_RED_SETTLE) && (r_state != S_RED_SETTLE);
        w_act_red_dc_nxt  = r_act_red_dc;
        w_act_red_pga_nxt = r_act_red_pga;
        w_act_ir_dc_nxt   = r_act_ir_dc;
        w_act_ir_pga_nxt  = r_act_ir_pga;
        if (w_enter_red) begin
            w_act_red_dc_nxt  = cfg_load ? cfg_red_dc  : r_shd_red_dc;
            w_act_red_pga_nxt = cfg_load ? cfg_red_pga : r_shd_red_pga;
            w_act_ir_dc_nxt   = cfg_load ? cfg_ir_dc   : r_shd_ir_dc;
            w_act_ir_pga_nxt  = cfg_load ? cfg_ir_pga  : r_shd_ir_pga;
        end
    end

    // Outputs follow the state being entered, so they switch on the same edge.
    // Ambient uses the RED settings to keep the AFE baseline comparable.
    always_comb begin
        w_led_red_nxt = 1'b0;
        w_led_ir_nxt  = 1'b0;
        w_dc_nxt      = '0;
        w_pga_nxt     = '0;
        case (phase_of(w_state_nxt))
            PH_RED: begin
                w_led_red_nxt = 1'b1;
                w_dc_nxt      = w_act_red_dc_nxt;
                w_pga_nxt     = w_act_red_pga_nxt;
            end
            PH_IR: begin
                w_led_ir_nxt  = 1'b1;
                w_dc_nxt      = w_act_ir_dc_nxt;
                w_pga_nxt     = w_act_ir_pga_nxt;
            end
            PH_AMB: begin
                w_dc_nxt      = w_act_red_dc_nxt;
                w_pga_nxt     = w_act_red_pga_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_shd_red_dc  <= '0;
            r_shd_red_pga <= '0;
            r_shd_ir_dc   <= '0;
            r_shd_ir_pga  <= '0;
            r_act_red_dc  <= '0;
            r_act_red_pga <= '0;
            r_act_ir_dc   <= '0;
            r_act_ir_pga  <= '0;
        end else begin
            if (cfg_load) begin
                r_shd_red_dc  <= cfg_red_dc;
                r_shd_red_pga <= cfg_red_pga;
                r_shd_ir_dc   <= cfg_ir_dc;
                r_shd_ir_pga  <= cfg_ir_pga;
            end
            r_act_red_dc  <= w_act_red_dc_nxt;
            r_act_red_pga <= w_act_red_pga_nxt;
            r_act_ir_dc   <= w_act_ir_dc_nxt;
            r_act_ir_pga  <= w_act_ir_pga_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            LED_RED  <= 1'b0;
            LED_IR   <= 1'b0;
            DC_Comp  <= '0;
            PGA_Gain <= '0;
            busy     <= 1'b0;
        end else begin
            LED_RED  <= w_led_red_nxt;
            LED_IR   <= w_led_ir_nxt;
            DC_Comp  <= w_dc_nxt;
            PGA_Gain <= w_pga_nxt;
            busy     <= (w_state_nxt != S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Shared accumulator and per-phase results
    // ------------------------------------------------------------------
    assign w_acc_clr = is_settle(r_state);
    assign w_acc_add = is_acq(r_state);

    sample_accumulator #(
        .ACQ_LOG2 (ACQ_LOG2)
    ) u_acc (
        .clk (CLK),
        .rst (rst),
        .clr (w_acc_clr),
        .add (w_acc_add),
        .ADC (ADC),
        .avg (w_avg)
    );

    // Last ambient sample: the ambient average is taken straight from the
    // accumulator so the triple lands one cycle after that sample.
    assign w_publish = (r_state == S_AMB_ACQ) && w_phase_done;

`ifdef AMB_SUB_EN
    assign w_red_pub = sat_sub(r_red_pend, w_avg);
    assign w_ir_pub  = sat_sub(r_ir_pend, w_avg);
`else
    assign w_red_pub = r_red_pend;
    assign w_ir_pub  = r_ir_pend;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_red_pend    <= '0;
            r_ir_pend     <= '0;
            RED_ADC_Value <= '0;
            IR_ADC_Value  <= '0;
            AMB_ADC_Value <= '0;
            sample_valid  <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            if ((r_state == S_RED_ACQ) && w_phase_done) begin
                r_red_pend <= w_avg;
            end
            if ((r_state == S_IR_ACQ) && w_phase_done) begin
                r_ir_pend <= w_avg;
            end
            sample_valid <= w_publish;
            if (w_publish) begin
                RED_ADC_Value <= w_red_pub;
                IR_ADC_Value  <= w_ir_pub;
                AMB_ADC_Value <= w_avg;
                frame_cnt     <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
